// File: rtl/hilo_pkg.sv
// Shared types and constants for the HI/LO sequencer.
package hilo_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_M_LAUNCH = 3'd1,
        ST_M_WAIT   = 3'd2,
        ST_D_LAUNCH = 3'd3,
        ST_D_WAIT   = 3'd4
    } state_t;

    localparam int STOP_GUARD = 2;
    localparam int ACC_W      = 64;

endpackage

// File: rtl/hilo_sequencer_if.sv
// Start/stop/result handshake between the sequencer and the Mult/Div units.
interface hilo_sequencer_if;
    logic        mult_start;
    logic        mult_stop;
    logic [31:0] mult_hi;
    logic [31:0] mult_lo;
    logic        div_start;
    logic        div_stop;
    logic [31:0] div_hi;
    logic [31:0] div_lo;
    logic        div_zero;

    modport master (
        output mult_start, div_start,
        input  mult_stop, mult_hi, mult_lo, div_stop, div_hi, div_lo, div_zero
    );

    modport slave (
        input  mult_start, div_start,
        output mult_stop, mult_hi, mult_lo, div_stop, div_hi, div_lo, div_zero
    );
endinterface

// File: rtl/hilo_watchdog.sv
// Wait-state cycle counter; expire pulses on the last allowed wait cycle.
module hilo_watchdog #(
    parameter int TIMEOUT_CYCLES = 40,
    parameter int CNT_W          = 6
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             clear,
    input  logic             run,
    output logic [CNT_W-1:0] count,
    output logic             expire
);

    always_ff @(posedge Clock) begin
        if (Reset || clear)
            count <= '0;
        else if (run)
            count <= count + 1'b1;
    end

    // Firing on count TIMEOUT_CYCLES-1 makes the counter "reach" TIMEOUT_CYCLES on this edge.
    assign expire = run && (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/hilo_sequencer.sv
// HI/LO owner: launches MULT/DIV, waits for stop, captures results, services MTHI/MTLO.
// Define HILO_MADD_EN to enable multiply-accumulate via i_MaddOp.
//
// state     | meaning
// ST_IDLE   | ready; accepts MT writes and op requests
// M_LAUNCH  | start pulse to multiplier, watchdog cleared
// M_WAIT    | waiting for multiplier stop (first STOP_GUARD cycles ignored)
// D_LAUNCH  | start pulse to divider, watchdog cleared
// D_WAIT    | waiting for divider stop (first STOP_GUARD cycles ignored)
module hilo_sequencer
    import hilo_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 40,
    parameter int CNT_W          = 6
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    i_MultOp,
    input  logic                    i_DivOp,
    input  logic                    i_MaddOp,
    hilo_sequencer_if.master        unit,
    input  logic                    i_MtHi,
    input  logic                    i_MtLo,
    input  logic [31:0]             i_WrData,
    output logic [31:0]             o_Hi,
    output logic [31:0]             o_Lo,
    output logic                    o_Busy,
    output logic                    o_DivByZero,
    output logic                    o_Timeout
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wd_cnt;
    logic             wd_expire;
    logic             launching, waiting, guard_ok;
    logic             mult_done, div_done, mt_wr, madd_req;

`ifdef HILO_MADD_EN
    logic             madd_q;
    logic [ACC_W-1:0] acc_sum;
    assign madd_req = i_MaddOp;
    assign acc_sum  = {o_Hi, o_Lo} + {unit.mult_hi, unit.mult_lo};
`else
    logic             unused_madd;
    assign madd_req    = 1'b0;
    assign unused_madd = i_MaddOp;
`endif

    assign launching = (state_q == ST_M_LAUNCH) || (state_q == ST_D_LAUNCH);
    assign waiting   = (state_q == ST_M_WAIT)   || (state_q == ST_D_WAIT);
    assign guard_ok  = wd_cnt >= CNT_W'(STOP_GUARD);
    assign mult_done = (state_q == ST_M_WAIT) && guard_ok && unit.mult_stop;
    assign div_done  = (state_q == ST_D_WAIT) && guard_ok && unit.div_stop;
    assign mt_wr     = i_MtHi || i_MtLo;

    hilo_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_watchdog (
        .Clock  (Clock),
        .Reset  (Reset),
        .clear  (launching),
        .run    (waiting),
        .count  (wd_cnt),
        .expire (wd_expire)
    );

    always_ff @(posedge Clock) begin
        if (Reset)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!mt_wr) begin
                    if (i_MultOp || madd_req)
                        state_d = ST_M_LAUNCH;
                    else if (i_DivOp)
                        state_d = ST_D_LAUNCH;
                end
            end
            ST_M_LAUNCH: state_d = ST_M_WAIT;
            ST_M_WAIT:   if (mult_done || wd_expire) state_d = ST_IDLE;
            ST_D_LAUNCH: state_d = ST_D_WAIT;
            ST_D_WAIT:   if (div_done || wd_expire) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        unit.mult_start = 1'b0;
        unit.div_start  = 1'b0;
        o_Busy          = 1'b1;
        case (state_q)
            ST_IDLE:     o_Busy          = 1'b0;
            ST_M_LAUNCH: unit.mult_start = 1'b1;
            ST_D_LAUNCH: unit.div_start  = 1'b1;
            default:     ;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            o_Hi        <= '0;
            o_Lo        <= '0;
            o_DivByZero <= 1'b0;
            o_Timeout   <= 1'b0;
`ifdef HILO_MADD_EN
            madd_q      <= 1'b0;
`endif
        end else begin
            if (state_q == ST_IDLE && mt_wr) begin
                if (i_MtHi) o_Hi <= i_WrData;
                if (i_MtLo) o_Lo <= i_WrData;
            end
`ifdef HILO_MADD_EN
            if (state_q == ST_IDLE && !mt_wr && (i_MultOp || i_MaddOp))
                madd_q <= !i_MultOp;
`endif
            if (launching)
                o_DivByZero <= 1'b0;
            if (mult_done) begin
`ifdef HILO_MADD_EN
                if (madd_q)
                    {o_Hi, o_Lo} <= acc_sum;
                else
                    {o_Hi, o_Lo} <= {unit.mult_hi, unit.mult_lo};
`else
                {o_Hi, o_Lo} <= {unit.mult_hi, unit.mult_lo};
`endif
            end
            if (div_done) begin
                o_DivByZero <= unit.div_zero;
                if (!unit.div_zero)
                    {o_Hi, o_Lo} <= {unit.div_hi, unit.div_lo};
            end
            // A stop seen on the final cycle still wins over the timeout.
            if (wd_expire && !mult_done && !div_done)
                o_Timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_hilo_sequencer.sv
// Directed self-checking bench for hilo_sequencer: vector table plus multi-cycle corner sequences.
module tb_hilo_sequencer;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        i_MultOp, i_DivOp, i_MaddOp, i_MtHi, i_MtLo;
    logic [31:0] i_WrData;
    logic [31:0] o_Hi, o_Lo;
    logic        o_Busy, o_DivByZero, o_Timeout;

    int n_checks = 0;
    int n_pass   = 0;
    int ms_seen  = 0;
    int ds_seen  = 0;

    hilo_sequencer_if u_if ();

    hilo_sequencer #(.TIMEOUT_CYCLES(40), .CNT_W(6)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .i_MultOp    (i_MultOp),
        .i_DivOp     (i_DivOp),
        .i_MaddOp    (i_MaddOp),
        .unit        (u_if.master),
        .i_MtHi      (i_MtHi),
        .i_MtLo      (i_MtLo),
        .i_WrData    (i_WrData),
        .o_Hi        (o_Hi),
        .o_Lo        (o_Lo),
        .o_Busy      (o_Busy),
        .o_DivByZero (o_DivByZero),
        .o_Timeout   (o_Timeout)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) begin
        if (u_if.mult_start) ms_seen = ms_seen + 1;
        if (u_if.div_start)  ds_seen = ds_seen + 1;
    end

    typedef struct {
        logic        mult, div, mthi, mtlo;
        logic [31:0] wdata;
        logic [31:0] uhi, ulo;
        logic        dz;
        int          stop_at;
        logic [31:0] ehi, elo;
        logic        edbz;
    } vec_t;

    vec_t vecs [8];

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic clear_req;
        i_MultOp = 0; i_DivOp = 0; i_MaddOp = 0; i_MtHi = 0; i_MtLo = 0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (o_Busy && n < 64) begin
            tick;
            n++;
        end
        check(name, o_Busy, 0);
    endtask

    task automatic apply(input int idx, input vec_t v);
        logic launch;
        launch  = (v.mult | v.div) & ~(v.mthi | v.mtlo);
        ms_seen = 0;
        ds_seen = 0;
        i_MultOp = v.mult; i_DivOp = v.div; i_MtHi = v.mthi; i_MtLo = v.mtlo;
        i_WrData = v.wdata;
        u_if.mult_hi = v.uhi; u_if.mult_lo = v.ulo;
        u_if.div_hi  = v.uhi; u_if.div_lo  = v.ulo; u_if.div_zero = v.dz;
        tick;
        clear_req;
        check($sformatf("v%0d_busy_cycle1", idx), o_Busy, launch);
        if (launch) begin
            repeat (v.stop_at) tick;
            u_if.mult_stop = v.mult;
            u_if.div_stop  = ~v.mult;
            wait_idle($sformatf("v%0d_done_bound", idx));
            u_if.mult_stop = 0;
            u_if.div_stop  = 0;
        end
        check($sformatf("v%0d_hi", idx), o_Hi, v.ehi);
        check($sformatf("v%0d_lo", idx), o_Lo, v.elo);
        check($sformatf("v%0d_dbz", idx), o_DivByZero, v.edbz);
        check($sformatf("v%0d_mstarts", idx), ms_seen, launch & v.mult);
        check($sformatf("v%0d_dstarts", idx), ds_seen, launch & ~v.mult);
    endtask

    initial begin
        //            mult div mthi mtlo wdata          uhi           ulo           dz stop ehi           elo           edbz
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'hFFFF_FFFA, 1'b0, 33, 32'h0,        32'hFFFF_FFFA, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h3,        32'h7,         1'b0, 20, 32'h3,        32'h7,         1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'hAA,       32'hBB,        1'b1, 10, 32'h3,        32'h7,         1'b1};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0,       32'h0,         1'b0, 0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        32'h11,       32'h22,        1'b0, 5,  32'h11,       32'h22,        1'b0};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h1234_5678, 32'h99,      32'h99,        1'b0, 5,  32'h1234_5678, 32'h22,       1'b0};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'hCAFE_F00D, 32'h0,       32'h0,         1'b0, 0,  32'h1234_5678, 32'hCAFE_F00D, 1'b0};
        vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h1,        32'h2,         1'b0, 5,  32'h1,        32'h2,         1'b0};

        Reset = 1;
        clear_req;
        i_WrData = 0;
        u_if.mult_stop = 0; u_if.mult_hi = 0; u_if.mult_lo = 0;
        u_if.div_stop  = 0; u_if.div_hi  = 0; u_if.div_lo  = 0; u_if.div_zero = 0;
        repeat (2) tick;
        Reset = 0;
        check("rst_hi", o_Hi, 0);
        check("rst_lo", o_Lo, 0);
        check("rst_busy", o_Busy, 0);
        check("rst_dbz", o_DivByZero, 0);
        check("rst_timeout", o_Timeout, 0);
        check("rst_starts", {u_if.mult_start, u_if.div_start}, 0);

        for (int i = 0; i < 8; i++) apply(i, vecs[i]);

        // Stale stop held high: guard must suppress capture; busy-time MT and op are ignored.
        ms_seen = 0; ds_seen = 0;
        u_if.mult_stop = 1; u_if.mult_hi = 32'h55; u_if.mult_lo = 32'h66;
        i_MultOp = 1;
        tick;
        clear_req;
        check("guard_busy_c1", o_Busy, 1);
        i_MtHi = 1; i_WrData = 32'hBAD0_BAD0; i_DivOp = 1;
        tick;
        clear_req;
        check("guard_hi_c2", o_Hi, 32'h1);
        tick;
        check("guard_hi_c3", o_Hi, 32'h1);
        check("guard_busy_c3", o_Busy, 1);
        tick;
        check("guard_lo_c4", o_Lo, 32'h2);
        tick;
        check("guard_busy_c5", o_Busy, 0);
        check("guard_hi_c5", o_Hi, 32'h55);
        check("guard_lo_c5", o_Lo, 32'h66);
        check("busy_divop_ignored", ds_seen, 0);
        check("guard_mstarts", ms_seen, 1);
        u_if.mult_stop = 0;

        // Watchdog: stop never comes.
        i_MultOp = 1;
        tick;
        clear_req;
        repeat (40) tick;
        check("wd_busy_c41", o_Busy, 1);
        check("wd_timeout_c41", o_Timeout, 0);
        tick;
        check("wd_timeout_c42", o_Timeout, 1);
        check("wd_busy_c42", o_Busy, 0);
        check("wd_hi", o_Hi, 32'h55);
        check("wd_lo", o_Lo, 32'h66);

        // Reset mid-operation with a stop arriving.
        i_DivOp = 1;
        tick;
        clear_req;
        repeat (2) tick;
        Reset = 1;
        u_if.div_stop = 1;
        tick;
        Reset = 0;
        u_if.div_stop = 0;
        check("midrst_busy", o_Busy, 0);
        check("midrst_hi", o_Hi, 0);
        check("midrst_lo", o_Lo, 0);
        check("midrst_timeout", o_Timeout, 0);
        check("midrst_dbz", o_DivByZero, 0);

`ifdef HILO_MADD_EN
        i_MtHi = 1; i_WrData = 32'h1;
        tick;
        clear_req;
        i_MtLo = 1; i_WrData = 32'hFFFF_FFFF;
        tick;
        clear_req;
        u_if.mult_hi = 32'h0; u_if.mult_lo = 32'h1;
        i_MaddOp = 1;
        tick;
        clear_req;
        check("madd_busy", o_Busy, 1);
        repeat (3) tick;
        u_if.mult_stop = 1;
        wait_idle("madd_done_bound");
        u_if.mult_stop = 0;
        check("madd_hi", o_Hi, 32'h2);
        check("madd_lo", o_Lo, 32'h0);
`else
        ms_seen = 0;
        i_MaddOp = 1;
        tick;
        clear_req;
        tick;
        check("madd_off_busy", o_Busy, 0);
        check("madd_off_starts", ms_seen, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
